// File: rtl/axil_slave_regfile.sv
// AXI4-Lite responder backed by a word-addressed register file with byte strobes.
// Write and read channels run as independent FSMs, each with one transaction in flight.
module axil_slave_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int RESP_WIDTH = 3,
   parameter int DEPTH      = 16
) (
   input  logic                    s_axi_aclk,
   input  logic                    s_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [RESP_WIDTH-1:0]   s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [RESP_WIDTH-1:0]   s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0]   LIMIT       = (ADDR_WIDTH + 1)'(DEPTH * BYTES);
   localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
   localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_HAVE_A = 2'd1,
      W_HAVE_D = 2'd2,
      W_RESP   = 2'd3
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_RESP = 1'b1
   } r_state_t;

   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      return ({1'b0, a} < LIMIT);
   endfunction

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   w_state_t              w_state_r, w_state_s;
   logic                  awready_r, awready_s;
   logic                  wready_r, wready_s;
   logic                  bvalid_r, bvalid_s;
   logic [RESP_WIDTH-1:0] bresp_r, bresp_s;
   logic [ADDR_WIDTH-1:0] aw_addr_r, aw_addr_s;
   logic [DATA_WIDTH-1:0] w_data_r, w_data_s;
   logic [BYTES-1:0]      w_strb_r, w_strb_s;
   logic                  commit_s;
   logic [ADDR_WIDTH-1:0] c_addr_s;
   logic [DATA_WIDTH-1:0] c_data_s;
   logic [BYTES-1:0]      c_strb_s;
   logic                  aw_hs_s, w_hs_s, ar_hs_s;

   r_state_t              r_state_r, r_state_s;
   logic                  arready_r, arready_s;
   logic                  rvalid_r, rvalid_s;
   logic [DATA_WIDTH-1:0] rdata_r, rdata_s;
   logic [RESP_WIDTH-1:0] rresp_r, rresp_s;

   // The extra top strobe bit comes from the bus width convention and carries no byte.
   logic unused_strb_s;
   assign unused_strb_s = s_axi_wstrb[BYTES];

   assign aw_hs_s = s_axi_awvalid & awready_r;
   assign w_hs_s  = s_axi_wvalid  & wready_r;
   assign ar_hs_s = s_axi_arvalid & arready_r;

   // Write channel next-state: pair up address and data, then issue a response.
   always_comb begin
      w_state_s = w_state_r;
      awready_s = awready_r;
      wready_s  = wready_r;
      bvalid_s  = bvalid_r;
      bresp_s   = bresp_r;
      aw_addr_s = aw_addr_r;
      w_data_s  = w_data_r;
      w_strb_s  = w_strb_r;
      commit_s  = 1'b0;
      c_addr_s  = aw_addr_r;
      c_data_s  = w_data_r;
      c_strb_s  = w_strb_r;
      case (w_state_r)
         W_IDLE: begin
            awready_s = 1'b1;
            wready_s  = 1'b1;
            if (aw_hs_s && w_hs_s) begin
               commit_s = 1'b1;
               c_addr_s = s_axi_awaddr;
               c_data_s = s_axi_wdata;
               c_strb_s = s_axi_wstrb[BYTES-1:0];
            end else if (aw_hs_s) begin
               aw_addr_s = s_axi_awaddr;
               awready_s = 1'b0;
               w_state_s = W_HAVE_A;
            end else if (w_hs_s) begin
               w_data_s  = s_axi_wdata;
               w_strb_s  = s_axi_wstrb[BYTES-1:0];
               wready_s  = 1'b0;
               w_state_s = W_HAVE_D;
            end else begin
               w_state_s = W_IDLE;
            end
         end
         W_HAVE_A: begin
            awready_s = 1'b0;
            wready_s  = 1'b1;
            if (w_hs_s) begin
               commit_s = 1'b1;
               c_data_s = s_axi_wdata;
               c_strb_s = s_axi_wstrb[BYTES-1:0];
            end else begin
               w_state_s = W_HAVE_A;
            end
         end
         W_HAVE_D: begin
            awready_s = 1'b1;
            wready_s  = 1'b0;
            if (aw_hs_s) begin
               commit_s = 1'b1;
               c_addr_s = s_axi_awaddr;
            end else begin
               w_state_s = W_HAVE_D;
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               bvalid_s  = 1'b0;
               awready_s = 1'b1;
               wready_s  = 1'b1;
               w_state_s = W_IDLE;
            end else begin
               w_state_s = W_RESP;
            end
         end
         default: begin
            w_state_s = W_IDLE;
            awready_s = 1'b0;
            wready_s  = 1'b0;
            bvalid_s  = 1'b0;
         end
      endcase
      if (commit_s) begin
         bvalid_s  = 1'b1;
         bresp_s   = addr_ok(c_addr_s) ? RESP_OKAY : RESP_SLVERR;
         awready_s = 1'b0;
         wready_s  = 1'b0;
         w_state_s = W_RESP;
      end else begin
         bresp_s = bresp_s;
      end
   end

   // Write channel state and output registers.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         w_state_r <= W_IDLE;
         awready_r <= 1'b0;
         wready_r  <= 1'b0;
         bvalid_r  <= 1'b0;
         bresp_r   <= RESP_OKAY;
         aw_addr_r <= '0;
         w_data_r  <= '0;
         w_strb_r  <= '0;
      end else begin
         w_state_r <= w_state_s;
         awready_r <= awready_s;
         wready_r  <= wready_s;
         bvalid_r  <= bvalid_s;
         bresp_r   <= bresp_s;
         aw_addr_r <= aw_addr_s;
         w_data_r  <= w_data_s;
         w_strb_r  <= w_strb_s;
      end
   end

   // Register file storage; only strobed bytes of an in-range commit change.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (commit_s && addr_ok(c_addr_s)) begin
         for (int b = 0; b < BYTES; b++) begin
            if (c_strb_s[b]) begin
               mem_r[c_addr_s[IDX_W+OFF_W-1:OFF_W]][b*8 +: 8] <= c_data_s[b*8 +: 8];
            end
         end
      end
   end

   // Read channel next-state; the array is sampled before any same-edge write lands.
   always_comb begin
      r_state_s = r_state_r;
      arready_s = arready_r;
      rvalid_s  = rvalid_r;
      rdata_s   = rdata_r;
      rresp_s   = rresp_r;
      case (r_state_r)
         R_IDLE: begin
            arready_s = 1'b1;
            if (ar_hs_s) begin
               arready_s = 1'b0;
               rvalid_s  = 1'b1;
               r_state_s = R_RESP;
               if (addr_ok(s_axi_araddr)) begin
                  rdata_s = mem_r[s_axi_araddr[IDX_W+OFF_W-1:OFF_W]];
                  rresp_s = RESP_OKAY;
               end else begin
                  rdata_s = '0;
                  rresp_s = RESP_SLVERR;
               end
            end else begin
               r_state_s = R_IDLE;
            end
         end
         R_RESP: begin
            if (s_axi_rready) begin
               rvalid_s  = 1'b0;
               arready_s = 1'b1;
               r_state_s = R_IDLE;
            end else begin
               r_state_s = R_RESP;
            end
         end
         default: begin
            r_state_s = R_IDLE;
            arready_s = 1'b0;
            rvalid_s  = 1'b0;
         end
      endcase
   end

   // Read channel state and output registers.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_state_r <= R_IDLE;
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rdata_r   <= '0;
         rresp_r   <= RESP_OKAY;
      end else begin
         r_state_r <= r_state_s;
         arready_r <= arready_s;
         rvalid_r  <= rvalid_s;
         rdata_r   <= rdata_s;
         rresp_r   <= rresp_s;
      end
   end

   assign s_axi_awready = awready_r;
   assign s_axi_wready  = wready_r;
   assign s_axi_bvalid  = bvalid_r;
   assign s_axi_bresp   = bresp_r;
   assign s_axi_arready = arready_r;
   assign s_axi_rvalid  = rvalid_r;
   assign s_axi_rdata   = rdata_r;
   assign s_axi_rresp   = rresp_r;

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Scoreboard bench for axil_slave_regfile: expected responses are queued when
// stimulus is issued and compared when the DUT completes each B/R handshake.
module tb_axil_slave_regfile;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int RW = 3;
   localparam int DEPTH = 16;
   localparam int SW = DW / 8 + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] awaddr = '0;
   logic          awvalid = 1'b0;
   logic          awready;
   logic [DW-1:0] wdata = '0;
   logic [SW-1:0] wstrb = '0;
   logic          wvalid = 1'b0;
   logic          wready;
   logic [RW-1:0] bresp;
   logic          bvalid;
   logic          bready = 1'b1;
   logic [AW-1:0] araddr = '0;
   logic          arvalid = 1'b0;
   logic          arready;
   logic [DW-1:0] rdata;
   logic [RW-1:0] rresp;
   logic          rvalid;
   logic          rready = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0]    model [DEPTH];
   logic [RW-1:0]    exp_b [$];
   logic [DW+RW-1:0] exp_r [$];

   always #5 clk = ~clk;

   axil_slave_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .DEPTH(DEPTH)) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic in_range(input logic [AW-1:0] a);
      return int'(a) < DEPTH * (DW / 8);
   endfunction

   task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      if (in_range(a)) begin
         for (int b = 0; b < DW / 8; b++) begin
            if (s[b]) model[a[5:2]][b*8 +: 8] = d[b*8 +: 8];
         end
         exp_b.push_back(3'd0);
      end else begin
         exp_b.push_back(3'd2);
      end
   endtask

   task automatic push_rd(input logic [AW-1:0] a);
      if (in_range(a)) exp_r.push_back({model[a[5:2]], 3'd0});
      else exp_r.push_back({32'd0, 3'd2});
   endtask

   task automatic send_aw(input logic [AW-1:0] a);
      awaddr = a;
      awvalid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (awready) break;
      end
      if (!awready) check_eq("aw_timeout", 64'd0, 64'd1);
      tick();
      awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
      wdata = d;
      wstrb = s;
      wvalid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (wready) break;
      end
      if (!wready) check_eq("w_timeout", 64'd0, 64'd1);
      tick();
      wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [AW-1:0] a);
      araddr = a;
      arvalid = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (arready) break;
      end
      if (!arready) check_eq("ar_timeout", 64'd0, 64'd1);
      tick();
      arvalid = 1'b0;
   endtask

   task automatic wait_b_done();
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (!bvalid) break;
      end
      check_eq("b_drain", {63'd0, bvalid}, 64'd0);
      tick();
   endtask

   task automatic wait_r_done();
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (!rvalid) break;
      end
      check_eq("r_drain", {63'd0, rvalid}, 64'd0);
      tick();
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      push_wr(a, d, s);
      fork
         send_aw(a);
         send_w(d, s);
      join
      check_eq("bvalid_lat", {63'd0, bvalid}, 64'd1);
      wait_b_done();
   endtask

   task automatic rd(input logic [AW-1:0] a);
      push_rd(a);
      send_ar(a);
      check_eq("rvalid_lat", {63'd0, rvalid}, 64'd1);
      wait_r_done();
   endtask

   // Scoreboard: pop and compare at every completed response handshake.
   always @(negedge clk) begin
      if (rst_n && bvalid && bready) begin
         if (exp_b.size() == 0) check_eq("b_extra", 64'd1, 64'd0);
         else check_eq("bresp", {61'd0, bresp}, {61'd0, exp_b.pop_front()});
      end
      if (rst_n && rvalid && rready) begin
         if (exp_r.size() == 0) check_eq("r_extra", 64'd1, 64'd0);
         else check_eq("rdata_rresp", {29'd0, rdata, rresp}, {29'd0, exp_r.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      repeat (3) tick();
      check_eq("rst_outs", {21'd0, awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("ready_pre", {61'd0, awready, wready, arready}, 64'd0);
      tick();
      check_eq("ready_post", {61'd0, awready, wready, arready}, 64'd7);

      wr(8'h00, 32'h0000_0038, 5'h0F);
      rd(8'h00);

      // Address leads data by two cycles
      wr(8'h08, 32'h0, 5'h0F);
      push_wr(8'h08, 32'hDEAD_BEEF, 5'h1F);
      send_aw(8'h08);
      for (int i = 0; i < 2; i++) begin
         check_eq("aw_wait_ready", {63'd0, awready}, 64'd0);
         check_eq("aw_wait_bvalid", {63'd0, bvalid}, 64'd0);
         tick();
      end
      send_w(32'hDEAD_BEEF, 5'h1F);
      check_eq("aw_lead_bvalid", {63'd0, bvalid}, 64'd1);
      wait_b_done();
      rd(8'h08);

      // Data leads address by two cycles
      wr(8'h08, 32'h0, 5'h0F);
      push_wr(8'h08, 32'hDEAD_BEEF, 5'h0F);
      send_w(32'hDEAD_BEEF, 5'h0F);
      for (int i = 0; i < 2; i++) begin
         check_eq("w_wait_ready", {63'd0, wready}, 64'd0);
         check_eq("w_wait_bvalid", {63'd0, bvalid}, 64'd0);
         tick();
      end
      send_aw(8'h08);
      check_eq("w_lead_bvalid", {63'd0, bvalid}, 64'd1);
      wait_b_done();
      rd(8'h08);

      wr(8'h18, 32'h1122_3344, 5'h0F);
      wr(8'h18, 32'hAABB_CCDD, 5'h05);
      rd(8'h18);
      wr(8'h18, 32'hFFFF_FFFF, 5'h00);
      rd(8'h1B);

      wr(8'h40, 32'h1234_5678, 5'h0F);
      rd(8'h40);
      rd(8'h00);
      rd(8'hFC);

      // Same-edge write commit and read of one word returns the old value
      wr(8'h0C, 32'h0101_0101, 5'h0F);
      push_rd(8'h0C);
      push_wr(8'h0C, 32'h0202_0202, 5'h0F);
      fork
         send_aw(8'h0C);
         send_w(32'h0202_0202, 5'h0F);
         send_ar(8'h0C);
      join
      check_eq("coll_bvalid", {63'd0, bvalid}, 64'd1);
      check_eq("coll_rvalid", {63'd0, rvalid}, 64'd1);
      wait_b_done();
      wait_r_done();
      rd(8'h0C);

      // Backpressure on B
      bready = 1'b0;
      push_wr(8'h04, 32'hCAFE_F00D, 5'h0F);
      fork
         send_aw(8'h04);
         send_w(32'hCAFE_F00D, 5'h0F);
      join
      for (int i = 0; i < 5; i++) begin
         check_eq("bhold", {60'd0, bvalid, bresp}, {60'd0, 1'b1, 3'd0});
         check_eq("bhold_rdy", {62'd0, awready, wready}, 64'd0);
         tick();
      end
      bready = 1'b1;
      tick();
      check_eq("brel", {61'd0, bvalid, awready, wready}, 64'd3);

      // Backpressure on R
      rready = 1'b0;
      push_rd(8'h04);
      send_ar(8'h04);
      for (int i = 0; i < 5; i++) begin
         check_eq("rhold", {31'd0, rvalid, rdata}, {31'd0, 1'b1, 32'hCAFE_F00D});
         check_eq("rhold_rdy", {63'd0, arready}, 64'd0);
         tick();
      end
      rready = 1'b1;
      tick();
      check_eq("rrel", {62'd0, rvalid, arready}, 64'd1);

      // Reset with address latched and data pending
      send_aw(8'h00);
      wdata = 32'hFFFF_FFFF;
      wstrb = 5'h0F;
      wvalid = 1'b1;
      rst_n = 1'b0;
      #2;
      check_eq("mid_rst_outs", {21'd0, awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}, 64'd0);
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      repeat (2) tick();
      @(negedge clk);
      wvalid = 1'b0;
      rst_n = 1'b1;
      #1;
      check_eq("mid_ready_pre", {61'd0, awready, wready, arready}, 64'd0);
      tick();
      check_eq("mid_ready_post", {61'd0, awready, wready, arready}, 64'd7);
      rd(8'h00);
      rd(8'h08);

      check_eq("b_left", 64'(exp_b.size()), 64'd0);
      check_eq("r_left", 64'(exp_r.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
